serial_pattern_gen: RTL

//   Bit-serial pattern transmitter that drives test and stimulus streams into
//   the serial sequence-detection path.
//   - On a start request, latches a PAT_W-bit pattern and emits it MSB-first,
//     one bit per clock, repeated repeat_n times.
//   - Inserts gap idle cycles between repetitions.
//   - Moore-style registered outputs with a one-cycle done pulse.

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_down_counter.sv | 41 ++++
 rtl/serial_pattern_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: the FSM state
// encoding and the default pattern constant.
package seq_pkg;

   // Gray-ordered encoding: IDLE -> SHIFT -> GAP -> DONE each differ by one bit
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      GAP   = 2'b11,
      DONE  = 2'b10
   } state_t;

   // Pattern sent when use_def is asserted at start
   localparam logic [3:0] PAT_DEF_C = 4'b1011;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with a zero flag. Decrement saturates at zero so the
// count never wraps. count_next exposes the value the register takes on the
// next edge so that registered outputs can be aligned with the counter.
module seq_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic [W-1:0] count_next,
   output logic         zero
);

   logic [W-1:0] count_reg;

   // Next count: load has priority, decrement only while non-zero
   always_comb begin
      count_next = count_reg;
      if (load) begin
         count_next = load_val;
      end else if (dec && (count_reg != '0)) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;
   assign zero  = (count_reg == '0);

endmodule

// File: rtl/serial_pattern_gen.sv
// Bit-serial pattern transmitter. On an accepted start it latches a pattern,
// a repeat count and a gap length, then sends the pattern MSB-first
// repeat_n times with gap idle cycles between repetitions, followed by a
// one-cycle done pulse. All outputs are registered from the next state so
// the first bit appears in the cycle right after start is sampled.
module serial_pattern_gen
   import seq_pkg::*;
#(
   parameter int                 PAT_W   = 4,
   parameter logic [PAT_W-1:0]   PAT_DEF = PAT_W'(PAT_DEF_C),
   parameter int                 CNT_W   = 8,
   parameter int                 GAP_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             use_def,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   localparam int               IDX_W   = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

   state_t state_reg, state_next;

   logic [PAT_W-1:0] pat_reg, pat_next;
   logic [GAP_W-1:0] gap_reg, gap_next;
   logic [CNT_W-1:0] rep_reg, rep_next;

   logic             accept;
   logic             idx_load, idx_dec, rep_dec;
   logic             gcnt_load, gcnt_dec;

   logic [IDX_W-1:0] idx_count, idx_count_next;
   logic             idx_zero;
   logic [GAP_W-1:0] gcnt_count, gcnt_count_next;
   logic             gcnt_zero;

   logic bit_out_reg, bit_valid_reg, frame_start_reg, busy_reg, done_reg;

   // Bit index within the current repetition, counts PAT_W-1 down to 0
   seq_down_counter #(.W(IDX_W)) u_idx_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (idx_load),
      .load_val   (IDX_MAX),
      .dec        (idx_dec),
      .count      (idx_count),
      .count_next (idx_count_next),
      .zero       (idx_zero)
   );

   // Idle cycles remaining between repetitions
   seq_down_counter #(.W(GAP_W)) u_gap_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (gcnt_load),
      .load_val   (gap_reg),
      .dec        (gcnt_dec),
      .count      (gcnt_count),
      .count_next (gcnt_count_next),
      .zero       (gcnt_zero)
   );

   // Only the registered index and the gap look-ahead are not needed here
   logic unused_cnt;
   assign unused_cnt = ^{idx_count, gcnt_count_next};

   // Next-state and counter control; abort overrides every transition
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      idx_load   = 1'b0;
      idx_dec    = 1'b0;
      rep_dec    = 1'b0;
      gcnt_load  = 1'b0;
      gcnt_dec   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!abort && start) begin
               accept = 1'b1;
               if (repeat_n == '0) begin
                  state_next = DONE;
               end else begin
                  state_next = SHIFT;
                  idx_load   = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (abort) begin
               state_next = IDLE;
            end else begin
               idx_dec = 1'b1;
               if (idx_zero) begin
                  rep_dec = 1'b1;
                  if (rep_reg <= CNT_W'(1)) begin
                     state_next = DONE;
                  end else if (gap_reg == '0) begin
                     idx_load = 1'b1;
                  end else begin
                     state_next = GAP;
                     gcnt_load  = 1'b1;
                  end
               end
            end
         end
         GAP: begin
            if (abort) begin
               state_next = IDLE;
            end else begin
               gcnt_dec = 1'b1;
               if (gcnt_zero || (gcnt_count == GAP_W'(1))) begin
                  state_next = SHIFT;
                  idx_load   = 1'b1;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Values latched at an accepted start, held for the whole frame
   always_comb begin
      pat_next = pat_reg;
      gap_next = gap_reg;
      rep_next = rep_reg;
      if (accept) begin
         pat_next = use_def ? PAT_DEF : pattern;
         gap_next = gap;
         rep_next = repeat_n;
      end else if (rep_dec && (rep_reg != '0)) begin
         rep_next = rep_reg - 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Frame parameter registers: pattern, gap length and remaining repeats
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_reg <= '0;
         gap_reg <= '0;
         rep_reg <= '0;
      end else begin
         pat_reg <= pat_next;
         gap_reg <= gap_next;
         rep_reg <= rep_next;
      end
   end

   // Output register, decoded from the state being entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_out_reg     <= 1'b0;
         bit_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         bit_out_reg     <= (state_next == SHIFT) && pat_next[idx_count_next];
         bit_valid_reg   <= (state_next == SHIFT);
         frame_start_reg <= (state_next == SHIFT) && (idx_count_next == IDX_MAX);
         busy_reg        <= (state_next == SHIFT) || (state_next == GAP);
         done_reg        <= (state_next == DONE);
      end
   end

   assign bit_out     = bit_out_reg;
   assign bit_valid   = bit_valid_reg;
   assign frame_start = frame_start_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;

endmodule
